// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: CPU slot, ICD handshake and SRAM pin bundle for sram_arbiter.
// The arbiter uses the slave modport; the CPU/ICD/SRAM environment uses master.
interface sram_arbiter_if;
  // CPU bus slot
  logic        cpu_req;
  logic        cpu_wr;
  logic [20:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_done;
  logic        cpu_ovf;
  // ICD (SPI debug) master
  logic        icd_req;
  logic        icd_wr;
  logic [20:0] icd_addr;
  logic [7:0]  icd_wdata;
  logic        icd_ack;
  logic [7:0]  icd_rdata;
  // SRAM pins
  logic [20:0] mem_addr;
  logic [7:0]  md_i;
  logic [7:0]  md_o;
  logic        md_oe;
  logic        m1cs_n;
  logic        mrd_n;
  logic        mwr_n;
  logic        busy;

  modport slave (
    input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    input  icd_req, icd_wr, icd_addr, icd_wdata,
    input  md_i,
    output cpu_rdata, cpu_done, cpu_ovf,
    output icd_ack, icd_rdata,
    output mem_addr, md_o, md_oe, m1cs_n, mrd_n, mwr_n, busy
  );

  modport master (
    output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    output icd_req, icd_wr, icd_addr, icd_wdata,
    output md_i,
    input  cpu_rdata, cpu_done, cpu_ovf,
    input  icd_ack, icd_rdata,
    input  mem_addr, md_o, md_oe, m1cs_n, mrd_n, mwr_n, busy
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM bus between the 65C02 CPU slot (priority) and
// the ICD debug master. Every access is SETUP / STROBE x STROBE_CYCLES / HOLD.
// Optional feature macro: SRAM_ARB_ROMWP_EN (CPU writes to addr[20]=1 are
// run as full accesses but never drive MD nor pulse MWRn).
module sram_arbiter #(
  parameter int STROBE_CYCLES = 2
) (
  input  logic          clk6x,
  input  logic          resetn,
  sram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic        owner_cpu;
  logic        cur_wr;
  logic        cur_wen;
  logic        cpu_pend;
  logic        pend_wr;
  logic [20:0] pend_addr;
  logic [7:0]  pend_wdata;

  logic [20:0] mem_addr;
  logic [7:0]  md_o;
  logic        md_oe;
  logic        m1cs_n;
  logic        mrd_n;
  logic        mwr_n;
  logic [7:0]  cpu_rdata;
  logic [7:0]  icd_rdata;
  logic        cpu_done;
  logic        icd_ack;
  logic        cpu_ovf;
  logic        busy;

  logic        arb_slot;
  logic        cpu_any;
  logic        icd_ok;
  logic        grant;
  logic        g_wr;
  logic        g_wen;
  logic [20:0] g_addr;
  logic [7:0]  g_wdata;

  // Grant selection: a fresh cpu_req beats (and replaces) a latched one.
  // An ICD access that is in its own HOLD still sees icd_req high, so it is
  // not re-granted there; the requester drops icd_req before the next IDLE.
  assign arb_slot = (state == IDLE) || (state == HOLD);
  assign cpu_any  = bus.cpu_req | cpu_pend;
  assign icd_ok   = bus.icd_req && ((state == IDLE) || owner_cpu);
  assign grant    = arb_slot && (cpu_any || icd_ok);
  assign g_wr     = cpu_any ? (bus.cpu_req ? bus.cpu_wr : pend_wr) : bus.icd_wr;
  assign g_addr   = cpu_any ? (bus.cpu_req ? bus.cpu_addr : pend_addr) : bus.icd_addr;
  assign g_wdata  = cpu_any ? (bus.cpu_req ? bus.cpu_wdata : pend_wdata) : bus.icd_wdata;
`ifdef SRAM_ARB_ROMWP_EN
  assign g_wen    = g_wr && !(cpu_any && g_addr[20]);
`else
  assign g_wen    = g_wr;
`endif

  // Access sequencer, CPU request latch and all registered bus outputs.
  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      owner_cpu  <= 1'b0;
      cur_wr     <= 1'b0;
      cur_wen    <= 1'b0;
      cpu_pend   <= 1'b0;
      pend_wr    <= 1'b0;
      pend_addr  <= 21'd0;
      pend_wdata <= 8'd0;
      mem_addr   <= 21'd0;
      md_o       <= 8'd0;
      md_oe      <= 1'b0;
      m1cs_n     <= 1'b1;
      mrd_n      <= 1'b1;
      mwr_n      <= 1'b1;
      cpu_rdata  <= 8'd0;
      icd_rdata  <= 8'd0;
      cpu_done   <= 1'b0;
      icd_ack    <= 1'b0;
      cpu_ovf    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      cpu_done <= 1'b0;
      icd_ack  <= 1'b0;
      if (bus.cpu_req && cpu_pend) cpu_ovf <= 1'b1;
      if (bus.cpu_req && (state == SETUP || state == STROBE)) begin
        cpu_pend   <= 1'b1;
        pend_wr    <= bus.cpu_wr;
        pend_addr  <= bus.cpu_addr;
        pend_wdata <= bus.cpu_wdata;
      end
      case (state)
        IDLE, HOLD: begin
          if (grant) begin
            state     <= SETUP;
            busy      <= 1'b1;
            owner_cpu <= cpu_any;
            cur_wr    <= g_wr;
            cur_wen   <= g_wen;
            mem_addr  <= g_addr;
            md_o      <= g_wdata;
            md_oe     <= g_wen;
            m1cs_n    <= 1'b0;
            if (cpu_any) cpu_pend <= 1'b0;
          end else begin
            state  <= IDLE;
            busy   <= 1'b0;
            md_oe  <= 1'b0;
            m1cs_n <= 1'b1;
          end
        end
        SETUP: begin
          state <= STROBE;
          cnt   <= 3'd1;
          mrd_n <= cur_wr;
          mwr_n <= ~cur_wen;
        end
        STROBE: begin
          if (cnt == 3'(STROBE_CYCLES)) begin
            state <= HOLD;
            mrd_n <= 1'b1;
            mwr_n <= 1'b1;
            if (owner_cpu) begin
              cpu_done <= 1'b1;
              if (!cur_wr) cpu_rdata <= bus.md_i;
            end else begin
              icd_ack <= 1'b1;
              if (!cur_wr) icd_rdata <= bus.md_i;
            end
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr  = mem_addr;
  assign bus.md_o      = md_o;
  assign bus.md_oe     = md_oe;
  assign bus.m1cs_n    = m1cs_n;
  assign bus.mrd_n     = mrd_n;
  assign bus.mwr_n     = mwr_n;
  assign bus.cpu_rdata = cpu_rdata;
  assign bus.icd_rdata = icd_rdata;
  assign bus.cpu_done  = cpu_done;
  assign bus.icd_ack   = icd_ack;
  assign bus.cpu_ovf   = cpu_ovf;
  assign bus.busy      = busy;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed scoreboard bench for sram_arbiter (STROBE_CYCLES=2).
module tb_sram_arbiter;
  localparam int S = 2;

  logic clk6x = 1'b0;
  logic resetn = 1'b0;
  sram_arbiter_if bus();

  sram_arbiter #(.STROBE_CYCLES(S)) dut (
    .clk6x (clk6x),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk6x = ~clk6x;

  // SRAM model
  logic [7:0] mem [0:65535];
  assign bus.md_i = mem[bus.mem_addr[15:0]];
  always @(posedge clk6x) begin
    if (!bus.m1cs_n && !bus.mwr_n) mem[bus.mem_addr[15:0]] <= bus.md_o;
  end

  typedef struct {
    logic [20:0] addr;
    logic        rd;
    logic [7:0]  data;
    int          rlo;
    int          wlo;
  } exp_t;

  exp_t cpu_q[$];
  exp_t icd_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: counts strobe/select cycles and checks each completion against the queue
  int cyc = 0, rlo = 0, wlo = 0;
  always @(negedge clk6x) begin
    exp_t e;
    if (!resetn) begin
      cyc = 0; rlo = 0; wlo = 0;
    end else begin
      if (!bus.m1cs_n) cyc++;
      if (!bus.mrd_n) rlo++;
      if (!bus.mwr_n) wlo++;
      if (bus.cpu_done || bus.icd_ack) begin
        if (bus.cpu_done && cpu_q.size() == 0) check("cpu_done_unexpected", 1, 0);
        else if (bus.icd_ack && icd_q.size() == 0) check("icd_ack_unexpected", 1, 0);
        else begin
          e = bus.cpu_done ? cpu_q.pop_front() : icd_q.pop_front();
          check("addr", 32'(bus.mem_addr), 32'(e.addr));
          check("access_len", cyc, S + 2);
          check("rd_strobe_cycles", rlo, e.rlo);
          check("wr_strobe_cycles", wlo, e.wlo);
          if (e.rd) check("rdata", 32'(bus.cpu_done ? bus.cpu_rdata : bus.icd_rdata), 32'(e.data));
          else check("md_o", 32'(bus.md_o), 32'(e.data));
          $display("[TB] %s %s addr=0x%05h data=0x%02h", bus.cpu_done ? "cpu" : "icd",
                   e.rd ? "rd" : "wr", e.addr, e.rd ? (bus.cpu_done ? bus.cpu_rdata : bus.icd_rdata) : bus.md_o);
        end
        cyc = 0; rlo = 0; wlo = 0;
      end
    end
  end

  function automatic exp_t mk(input logic [20:0] a, input logic rd, input logic [7:0] d, input int wl);
    exp_t e;
    e.addr = a; e.rd = rd; e.data = d; e.rlo = rd ? S : 0; e.wlo = wl;
    return e;
  endfunction

  task automatic cpu_pulse(input logic wr, input logic [20:0] a, input logic [7:0] d);
    @(posedge clk6x); #1;
    bus.cpu_req = 1'b1; bus.cpu_wr = wr; bus.cpu_addr = a; bus.cpu_wdata = d;
    @(posedge clk6x); #1;
    bus.cpu_req = 1'b0;
  endtask

  task automatic icd_access(input logic wr, input logic [20:0] a, input logic [7:0] d);
    int n;
    @(posedge clk6x); #1;
    bus.icd_req = 1'b1; bus.icd_wr = wr; bus.icd_addr = a; bus.icd_wdata = d;
    n = 0;
    do begin
      @(posedge clk6x); #1; n++;
    end while (!bus.icd_ack && n < 60);
    if (!bus.icd_ack) check("icd_ack_timeout", 0, 1);
    @(posedge clk6x); #1;
    bus.icd_req = 1'b0;
  endtask

  // Cycles from the first completion pulse to the second one
  task automatic gap(input logic cpu_first, input int exp);
    int n;
    n = 0;
    do begin
      @(posedge clk6x); #1; n++;
    end while (!(cpu_first ? bus.cpu_done : bus.icd_ack) && n < 60);
    n = 0;
    do begin
      @(posedge clk6x); #1; n++;
    end while (!(cpu_first ? bus.icd_ack : bus.cpu_done) && n < 60);
    check(cpu_first ? "gap_cpu_to_icd" : "gap_icd_to_cpu", n, exp);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(posedge clk6x); #1; n++;
    end while (bus.busy && n < 60);
    if (bus.busy) check("idle_timeout", 0, 1);
  endtask

  task automatic wait_wr_strobe();
    int n;
    n = 0;
    do begin
      @(posedge clk6x); #1; n++;
    end while (bus.mwr_n && n < 20);
    if (bus.mwr_n) check("strobe_timeout", 0, 1);
  endtask

  initial begin
    bus.cpu_req = 0; bus.cpu_wr = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.icd_req = 0; bus.icd_wr = 0; bus.icd_addr = '0; bus.icd_wdata = '0;

    // Reset state
    repeat (3) @(posedge clk6x);
    #1;
    check("rst_m1cs_n", 32'(bus.m1cs_n), 1);
    check("rst_mrd_n", 32'(bus.mrd_n), 1);
    check("rst_mwr_n", 32'(bus.mwr_n), 1);
    check("rst_md_oe", 32'(bus.md_oe), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_mem_addr", 32'(bus.mem_addr), 0);
    check("rst_cpu_rdata", 32'(bus.cpu_rdata), 0);
    check("rst_ovf", 32'(bus.cpu_ovf), 0);
    resetn = 1'b1;

    // CPU writes then read back
    cpu_q.push_back(mk(21'h00010, 0, 8'h12, S)); cpu_pulse(1, 21'h00010, 8'h12); wait_idle();
    cpu_q.push_back(mk(21'h00011, 0, 8'h34, S)); cpu_pulse(1, 21'h00011, 8'h34); wait_idle();
    cpu_q.push_back(mk(21'h1F000, 0, 8'hAB, S)); cpu_pulse(1, 21'h1F000, 8'hAB); wait_idle();
    cpu_q.push_back(mk(21'h00010, 1, 8'h12, 0)); cpu_pulse(0, 21'h00010, 8'h00); wait_idle();

    // Simultaneous CPU read and ICD write: CPU first, ICD back-to-back
    cpu_q.push_back(mk(21'h00011, 1, 8'h34, 0));
    icd_q.push_back(mk(21'h00020, 0, 8'h56, S));
    fork
      cpu_pulse(0, 21'h00011, 8'h00);
      icd_access(1, 21'h00020, 8'h56);
      gap(1'b1, S + 2);
    join
    wait_idle();
    cpu_q.push_back(mk(21'h00020, 1, 8'h56, 0)); cpu_pulse(0, 21'h00020, 8'h00); wait_idle();

    // CPU requests during an ICD write; second request overwrites the first
    icd_q.push_back(mk(21'h00030, 0, 8'h77, S));
    cpu_q.push_back(mk(21'h00010, 1, 8'h12, 0));
    fork
      icd_access(1, 21'h00030, 8'h77);
      begin
        wait_wr_strobe();
        bus.cpu_req = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = 21'h00011;
        @(posedge clk6x); #1;
        bus.cpu_addr = 21'h00010;
        @(posedge clk6x); #1;
        bus.cpu_req = 1'b0;
      end
      gap(1'b0, S + 2);
    join
    wait_idle();
    check("ovf_set", 32'(bus.cpu_ovf), 1);

    // ICD read, then drop request: back to IDLE
    icd_q.push_back(mk(21'h1F000, 1, 8'hAB, 0));
    icd_access(0, 21'h1F000, 8'h00);
    check("icd_idle_busy", 32'(bus.busy), 0);
    check("icd_idle_cs", 32'(bus.m1cs_n), 1);
    repeat (3) @(posedge clk6x);

    // Write into the ROM half
`ifdef SRAM_ARB_ROMWP_EN
    cpu_q.push_back(mk(21'h180000, 0, 8'h99, 0));
`else
    cpu_q.push_back(mk(21'h180000, 0, 8'h99, S));
`endif
    cpu_pulse(1, 21'h180000, 8'h99); wait_idle();

    // Reset in the middle of a write strobe
    cpu_pulse(1, 21'h00040, 8'h11);
    wait_wr_strobe();
    resetn = 1'b0;
    #1;
    check("rst_mid_mwr_n", 32'(bus.mwr_n), 1);
    check("rst_mid_cs", 32'(bus.m1cs_n), 1);
    check("rst_mid_md_oe", 32'(bus.md_oe), 0);
    check("rst_mid_busy", 32'(bus.busy), 0);
    @(posedge clk6x); #1;
    resetn = 1'b1;
    repeat (6) @(posedge clk6x);
    #1;
    check("post_rst_busy", 32'(bus.busy), 0);
    check("post_rst_ovf", 32'(bus.cpu_ovf), 0);
    check("cpu_q_drained", cpu_q.size(), 0);
    check("icd_q_drained", icd_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule
